// File: rtl/jtopl_seq_pkg.sv
// Shared constants, record types and slot decode for the OPL operator-slot sequencer.
package jtopl_seq_pkg;

    localparam int unsigned NSLOT     = 18;
    localparam int unsigned NCH       = 9;
    localparam int unsigned RHY_CH_LO = 7;

    typedef struct packed {
        logic [3:0] ch;
        logic       op;
        logic       zero;
    } dec_t;

    // One pipeline record as consumed by the accumulator.
    typedef struct packed {
        logic [4:0] slot;
        logic [3:0] ch;
        logic       op;
        logic       con;
        logic       zero;
        logic       rhy_IV;
    } rec_t;

    // Slot order: mod ch0-2, car ch0-2, mod ch3-5, car ch3-5, mod ch6-8, car ch6-8.
    function automatic dec_t slot_dec(input logic [4:0] s);
        dec_t       d;
        logic [4:0] blk;
        logic [4:0] r;
        logic [4:0] r3;
        blk    = s / 5'd6;
        r      = s - blk * 5'd6;
        r3     = (r >= 5'd3) ? r - 5'd3 : r;
        d.op   = (r >= 5'd3);
        d.ch   = 4'(blk * 5'd3 + r3);
        d.zero = (s == 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/jtopl_slot_seq_if.sv
// Control and per-slot output bundle between the sequencer and the accumulator path.
interface jtopl_slot_seq_if;

    logic       cenop;
    logic [8:0] con_in;
    logic       rhy_en;
    logic [4:0] slot;
    logic [3:0] ch;
    logic       op;
    logic       con;
    logic       zero;
    logic       rhy_IV;
    logic       frame_ok;

    modport master (
        output cenop, con_in, rhy_en,
        input  slot, ch, op, con, zero, rhy_IV, frame_ok
    );

    modport slave (
        input  cenop, con_in, rhy_en,
        output slot, ch, op, con, zero, rhy_IV, frame_ok
    );

endinterface

// File: rtl/jtopl_seq_dly.sv
// cenop-enabled shift register, DLY+1 stages deep, synchronous active-low reset to zero.
module jtopl_seq_dly #(
    parameter int unsigned W   = 13,
    parameter int unsigned DLY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cenop,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] last_d
);

    logic [DLY:0][W-1:0] sr;

    // last_d is the word the output stage will capture on the next cenop.
    generate
        if (DLY == 0) begin : g_one
            always_ff @(posedge clk) begin
                if (!rst)       sr <= '0;
                else if (cenop) sr <= d;
            end
            assign last_d = d;
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (!rst)       sr <= '0;
                else if (cenop) sr <= {sr[DLY-1:0], d};
            end
            assign last_d = sr[DLY-1];
        end
    endgenerate

    assign q = sr[DLY];

endmodule

// File: rtl/jtopl_slot_seq.sv
// Operator-slot sequencer: slot counter, frame-boundary shadows, decode and aligned output delay.
module jtopl_slot_seq
    import jtopl_seq_pkg::*;
#(
    parameter int unsigned DLY = 2
) (
    input  logic               clk,
    input  logic               rst,
    jtopl_slot_seq_if.slave    bus
);

    logic [4:0]     s_cnt;
    logic [NCH-1:0] con_sh;
    logic           rhy_sh;
    logic           frame_ok_r;
    dec_t           dec;
    rec_t           rec_d;
    rec_t           rec_q;
    rec_t           rec_last;

    // Shadows load alongside the slot-17 capture, so slot 17 still sees the old values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_cnt  <= '0;
            con_sh <= '0;
            rhy_sh <= 1'b0;
        end else if (bus.cenop) begin
            s_cnt <= (s_cnt >= 5'(NSLOT - 1)) ? '0 : s_cnt + 5'd1;
            if (s_cnt == 5'(NSLOT - 1)) begin
                con_sh <= bus.con_in;
                rhy_sh <= bus.rhy_en;
            end
        end
    end

    always_comb begin
        rec_d        = '0;
        dec          = slot_dec(s_cnt);
        rec_d.slot   = s_cnt;
        rec_d.ch     = dec.ch;
        rec_d.op     = dec.op;
        rec_d.zero   = dec.zero;
        rec_d.con    = (dec.ch < 4'(NCH)) ? con_sh[dec.ch] : 1'b0;
        rec_d.rhy_IV = rhy_sh & ((dec.ch == 4'(RHY_CH_LO)) || (dec.ch == 4'(RHY_CH_LO + 1)));
    end

    jtopl_seq_dly #(
        .W   ($bits(rec_t)),
        .DLY (DLY)
    ) u_dly (
        .clk    (clk),
        .rst    (rst),
        .cenop  (bus.cenop),
        .d      (rec_d),
        .q      (rec_q),
        .last_d (rec_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) frame_ok_r <= 1'b0;
        else      frame_ok_r <= bus.cenop & rec_last.zero;
    end

    assign bus.slot     = rec_q.slot;
    assign bus.ch       = rec_q.ch;
    assign bus.op       = rec_q.op;
    assign bus.con      = rec_q.con;
    assign bus.zero     = rec_q.zero;
    assign bus.rhy_IV   = rec_q.rhy_IV;
    assign bus.frame_ok = frame_ok_r;

endmodule

// File: tb/tb_jtopl_slot_seq.sv
// Directed table-driven bench: DLY=2 with sparse cenop, plus DLY=0 with cenop tied high.
module tb_jtopl_slot_seq;

    typedef struct {
        logic [8:0] con_in;
        logic       rhy_en;
        int         slot;
        int         ch;
        int         op;
        int         con;
        int         zero;
        int         rhy;
        int         fok;
    } vec_t;

    localparam int NSTEP = 68;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   total;
    int   bad;
    int   cur_step;
    bit   done;

    jtopl_slot_seq_if bus_a ();
    jtopl_slot_seq_if bus_b ();

    jtopl_slot_seq #(.DLY(2)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
    jtopl_slot_seq #(.DLY(0)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t       tbl [1:NSTEP];
    logic [8:0] con_at [0:NSTEP];
    logic       rhy_at [0:NSTEP];
    int         ch_lut [0:17] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 6, 7, 8};

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0d want=%0d", nm, cur_step, act, exp);
        end
    endtask

    task automatic chk_a(input vec_t v);
        chk("a_slot", int'(bus_a.slot), v.slot);
        chk("a_ch", int'(bus_a.ch), v.ch);
        chk("a_op", int'(bus_a.op), v.op);
        chk("a_con", int'(bus_a.con), v.con);
        chk("a_zero", int'(bus_a.zero), v.zero);
        chk("a_rhy_IV", int'(bus_a.rhy_IV), v.rhy);
        chk("a_frame_ok", int'(bus_a.frame_ok), v.fok);
    endtask

    // One cenop pulse every 4th clk; outputs checked half a cycle after the cenop edge.
    task automatic a_step(input vec_t v);
        @(negedge clk);
        bus_a.con_in = v.con_in;
        bus_a.rhy_en = v.rhy_en;
        bus_a.cenop  = 1'b1;
        @(negedge clk);
        bus_a.cenop = 1'b0;
        chk_a(v);
        @(negedge clk);
        chk("a_frame_ok_drop", int'(bus_a.frame_ok), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog step=%0d got=timeout want=finish", cur_step);
            $fatal(1, "timeout");
        end
    end

    initial begin
        vec_t zv;
        total    = 0;
        bad      = 0;
        cur_step = 0;
        done     = 1'b0;

        // Expected table: output at step k reflects the capture made at step k-2.
        for (int k = 1; k <= NSTEP; k++) begin
            con_at[k] = (k < 9) ? 9'h000 : (k < 30) ? 9'h1FF : 9'h0A5;
            rhy_at[k] = (k >= 30);
        end
        con_at[0] = '0;
        rhy_at[0] = 1'b0;
        for (int k = 1; k <= NSTEP; k++) begin
            int         j;
            int         s;
            int         m;
            logic [8:0] csh;
            logic       rsh;
            tbl[k].con_in = con_at[k];
            tbl[k].rhy_en = rhy_at[k];
            j = k - 2;
            if (j < 1) begin
                tbl[k].slot = 0; tbl[k].ch = 0; tbl[k].op = 0; tbl[k].con = 0;
                tbl[k].zero = 0; tbl[k].rhy = 0; tbl[k].fok = 0;
            end else begin
                s   = (j - 1) % 18;
                m   = ((j - 1) / 18) * 18;
                csh = (m >= 18) ? con_at[m] : 9'h000;
                rsh = (m >= 18) ? rhy_at[m] : 1'b0;
                tbl[k].slot = s;
                tbl[k].ch   = ch_lut[s];
                tbl[k].op   = (s / 3) % 2;
                tbl[k].con  = int'(csh[ch_lut[s]]);
                tbl[k].zero = (s == 0) ? 1 : 0;
                tbl[k].rhy  = (rsh && ch_lut[s] >= 7) ? 1 : 0;
                tbl[k].fok  = tbl[k].zero;
            end
        end
        zv = '{9'h000, 1'b0, 0, 0, 0, 0, 0, 0, 0};

        // Reset state, with cenop asserted during reset to confirm reset priority.
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.cenop = 1'b0; bus_a.con_in = '0; bus_a.rhy_en = 1'b0;
        bus_b.cenop = 1'b1; bus_b.con_in = 9'h1FF; bus_b.rhy_en = 1'b0;
        repeat (2) @(negedge clk);
        bus_a.cenop = 1'b1;
        @(negedge clk);
        bus_a.cenop = 1'b0;
        @(negedge clk);
        chk_a(zv);
        chk("a_s_cnt_reset", int'(dut_a.s_cnt), 0);
        rst_a = 1'b1;

        for (int k = 1; k <= NSTEP; k++) begin
            cur_step = k;
            a_step(tbl[k]);
        end

        // Mid-frame reset while the output holds slot 11 and cenop is low.
        chk("a_slot_before_rst", int'(bus_a.slot), 11);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        cur_step = 1000;
        chk_a(zv);
        chk("a_s_cnt_midrst", int'(dut_a.s_cnt), 0);
        rst_a = 1'b1;

        // Restart: shadows are back to 0 even though con_in/rhy_en are nonzero.
        for (int k = 1; k <= 3; k++) begin
            vec_t v;
            v = zv;
            v.con_in = 9'h0A5;
            v.rhy_en = 1'b1;
            if (k == 3) begin
                v.zero = 1;
                v.fok  = 1;
            end
            cur_step = 1000 + k;
            a_step(v);
        end

        // DLY=0, cenop tied high: one slot per clk, frame_ok every 18 clk.
        @(negedge clk);
        rst_b = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            int s;
            @(negedge clk);
            cur_step = 2000 + n;
            s = (n - 1) % 18;
            chk("b_slot", int'(bus_b.slot), s);
            chk("b_ch", int'(bus_b.ch), ch_lut[s]);
            chk("b_zero", int'(bus_b.zero), (s == 0) ? 1 : 0);
            chk("b_frame_ok", int'(bus_b.frame_ok), (s == 0) ? 1 : 0);
            chk("b_con", int'(bus_b.con), (n >= 19) ? 1 : 0);
        end

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
